mdu_seq: RTL and testbench

Multi-cycle iterative multiply/divide unit that replaces the single-cycle combinational MDU path feeding the HI and LO registers. It accepts an operation from the EX stage and runs a radix-2 shift-add multiply or restoring divide over WIDTH cycles. It then drives one write pulse to HI and LO, and holds busy high so the hazard unit stalls MFHI/MFLO and subsequent MDU ops.

---
 rtl/mdu_seq_pkg.sv | 30 +++
 rtl/mdu_seq_if.sv | 31 +++
 rtl/mdu_seq_abs.sv | 13 +
 rtl/mdu_seq.sv | 181 ++++++++++++++++++
 tb/tb_mdu_seq.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mdu_seq_pkg.sv
// Shared definitions for the iterative multiply/divide unit: operation codes,
// FSM state encoding and small operation-decoding helpers.
package mdu_seq_pkg;

  localparam int MDUOP_WIDTH = 2;
  localparam int MDUST_WIDTH = 2;

  typedef enum logic [MDUOP_WIDTH-1:0] {
    MDU_MULT  = 2'd0,
    MDU_MULTU = 2'd1,
    MDU_DIV   = 2'd2,
    MDU_DIVU  = 2'd3
  } mdu_op_e;

  typedef enum logic [MDUST_WIDTH-1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2,
    ST_WB   = 2'd3
  } mdu_state_e;

  function automatic logic op_is_div(input mdu_op_e op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

  function automatic logic op_is_signed(input mdu_op_e op);
    return (op == MDU_MULT) || (op == MDU_DIV);
  endfunction

endpackage

// File: rtl/mdu_seq_if.sv
// EX-stage request and HI/LO write-back bundle of the multiply/divide unit.
// The master is the pipeline side, the slave is the MDU itself.
interface mdu_seq_if
  import mdu_seq_pkg::*;
#(
  parameter int WIDTH = 32
) ();

  logic             start;
  mdu_op_e          op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cancel;
  logic             busy;
  logic             done;
  logic             hi_wr;
  logic             lo_wr;
  logic [WIDTH-1:0] hi_wd;
  logic [WIDTH-1:0] lo_wd;

  modport master (
    output start, op, a, b, cancel,
    input  busy, done, hi_wr, lo_wr, hi_wd, lo_wd
  );

  modport slave (
    input  start, op, a, b, cancel,
    output busy, done, hi_wr, lo_wr, hi_wd, lo_wd
  );

endinterface

// File: rtl/mdu_seq_abs.sv
// Conditional two's-complement negate. Used both to take operand magnitudes
// and to restore the sign of products, quotients and remainders.
module mdu_abs #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] din,
  input  logic             neg,
  output logic [WIDTH-1:0] dout
);

  assign dout = neg ? (~din + WIDTH'(1)) : din;

endmodule

// File: rtl/mdu_seq.sv
// Iterative radix-2 multiply / restoring divide unit. An operation runs for a
// fixed WIDTH+2 cycles (RUN iterations, one FIX cycle for sign correction and
// one WB cycle that pulses the HI/LO write enables), holding busy throughout.
module mdu_seq
  import mdu_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     rst_n,
  mdu_seq_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH - 1);

  mdu_state_e       state_q;
  mdu_state_e       state_d;
  mdu_op_e          op_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] opnd_q;
  logic [WIDTH-1:0] a_raw_q;
  logic [CW-1:0]    cnt_q;
  logic             sign_a_q;
  logic             sign_b_q;
  logic             div_zero_q;

  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] hi_wd_q;
  logic [WIDTH-1:0] lo_wd_q;

  logic             launch;
  logic             neg_a_in;
  logic             neg_b_in;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic             is_div_q;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   div_trial;

  logic             neg_prod_en;
  logic             neg_quo_en;
  logic             neg_rem_en;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;
  logic [WIDTH-1:0] res_hi;
  logic [WIDTH-1:0] res_lo;

  assign launch   = (state_q == ST_IDLE) && bus.start && !bus.cancel;
  assign neg_a_in = op_is_signed(bus.op) && bus.a[WIDTH-1];
  assign neg_b_in = op_is_signed(bus.op) && bus.b[WIDTH-1];
  assign is_div_q = op_is_div(op_q);

  mdu_abs #(.WIDTH(WIDTH)) u_abs_a (.din(bus.a), .neg(neg_a_in), .dout(abs_a));
  mdu_abs #(.WIDTH(WIDTH)) u_abs_b (.din(bus.b), .neg(neg_b_in), .dout(abs_b));

  assign mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
  assign rem_shift = {hi_q, lo_q[WIDTH-1]};
  assign div_trial = rem_shift - {1'b0, opnd_q};

  assign neg_prod_en = (op_q == MDU_MULT) && (sign_a_q ^ sign_b_q);
  assign neg_quo_en  = (op_q == MDU_DIV) && (sign_a_q ^ sign_b_q);
  assign neg_rem_en  = (op_q == MDU_DIV) && sign_a_q;

  mdu_abs #(.WIDTH(2*WIDTH)) u_neg_prod (.din({hi_q, lo_q}), .neg(neg_prod_en), .dout(prod_fix));
  mdu_abs #(.WIDTH(WIDTH))   u_neg_quo  (.din(lo_q), .neg(neg_quo_en), .dout(quo_fix));
  mdu_abs #(.WIDTH(WIDTH))   u_neg_rem  (.din(hi_q), .neg(neg_rem_en), .dout(rem_fix));

  // Pick the signed-corrected result, overriding it for divide by zero
  always_comb begin
    res_hi = prod_fix[2*WIDTH-1:WIDTH];
    res_lo = prod_fix[WIDTH-1:0];
    if (is_div_q) begin
      if (div_zero_q) begin
        res_hi = a_raw_q;
        res_lo = '1;
      end else begin
        res_hi = rem_fix;
        res_lo = quo_fix;
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: cancel aborts anything not yet committed to write-back
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (launch) state_d = ST_RUN;
      ST_RUN: begin
        if (bus.cancel) begin
          state_d = ST_IDLE;
        end else if (cnt_q == '0) begin
          state_d = ST_FIX;
        end
      end
      ST_FIX:  state_d = bus.cancel ? ST_IDLE : ST_WB;
      ST_WB:   state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Operand capture on launch, then one shift-add or restoring step per RUN cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q       <= MDU_MULT;
      hi_q       <= '0;
      lo_q       <= '0;
      opnd_q     <= '0;
      a_raw_q    <= '0;
      cnt_q      <= '0;
      sign_a_q   <= 1'b0;
      sign_b_q   <= 1'b0;
      div_zero_q <= 1'b0;
    end else if (launch) begin
      op_q       <= bus.op;
      a_raw_q    <= bus.a;
      sign_a_q   <= neg_a_in;
      sign_b_q   <= neg_b_in;
      div_zero_q <= (bus.b == '0);
      cnt_q      <= CNT_INIT;
      hi_q       <= '0;
      if (op_is_div(bus.op)) begin
        lo_q   <= abs_a;
        opnd_q <= abs_b;
      end else begin
        lo_q   <= abs_b;
        opnd_q <= abs_a;
      end
    end else if (state_q == ST_RUN) begin
      if (cnt_q != '0) begin
        cnt_q <= cnt_q - CW'(1);
      end
      if (is_div_q) begin
        hi_q <= div_trial[WIDTH] ? rem_shift[WIDTH-1:0] : div_trial[WIDTH-1:0];
        lo_q <= {lo_q[WIDTH-2:0], ~div_trial[WIDTH]};
      end else begin
        hi_q <= mul_sum[WIDTH:1];
        lo_q <= {mul_sum[0], lo_q[WIDTH-1:1]};
      end
    end
  end

  // Registered outputs: busy tracks the next state, write data latched on FIX->WB
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_wd_q <= '0;
      lo_wd_q <= '0;
    end else begin
      busy_q <= (state_d != ST_IDLE);
      done_q <= (state_d == ST_WB);
      if ((state_q == ST_FIX) && (state_d == ST_WB)) begin
        hi_wd_q <= res_hi;
        lo_wd_q <= res_lo;
      end
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.hi_wr = done_q;
  assign bus.lo_wr = done_q;
  assign bus.hi_wd = hi_wd_q;
  assign bus.lo_wd = lo_wd_q;

endmodule

// File: tb/tb_mdu_seq.sv
// Self-checking bench for mdu_seq: directed vector table, control-corner
// sequences (start while busy, cancel, back-to-back, reset mid-op) and
// randomized operations checked against an arithmetic reference model.
module tb_mdu_seq
  import mdu_seq_pkg::*;
;

  localparam int W       = 32;
  localparam int LAT     = W + 2;
  localparam int INJ_NONE   = 0;
  localparam int INJ_START  = 1;
  localparam int INJ_CANCEL = 2;
  localparam int INJ_RESET  = 3;

  typedef struct {
    mdu_op_e     op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  mdu_seq_if #(.WIDTH(W)) bus ();

  mdu_seq #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run always terminates
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model computed directly from arithmetic rules
  function automatic void refModel(input mdu_op_e op, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] hi, output logic [31:0] lo);
    logic signed [63:0] sp;
    logic [63:0]        up;
    int                 sa;
    int                 sb;
    sa = int'(a);
    sb = int'(b);
    hi = '0;
    lo = '0;
    case (op)
      MDU_MULT: begin
        sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        hi = sp[63:32];
        lo = sp[31:0];
      end
      MDU_MULTU: begin
        up = {32'd0, a} * {32'd0, b};
        hi = up[63:32];
        lo = up[31:0];
      end
      MDU_DIV: begin
        if (b == 32'd0) begin
          hi = a;
          lo = 32'hFFFF_FFFF;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          hi = 32'd0;
          lo = a;
        end else begin
          lo = 32'(sa / sb);
          hi = 32'(sa % sb);
        end
      end
      default: begin
        if (b == 32'd0) begin
          hi = a;
          lo = 32'hFFFF_FFFF;
        end else begin
          lo = a / b;
          hi = a % b;
        end
      end
    endcase
  endfunction

  // Launch: start is driven for one cycle from the current negedge
  task automatic applyStimulus(input mdu_op_e op, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Observe ncyc cycles after launch, optionally injecting a control event
  task automatic collectResult(input int ncyc, input int inj_kind, input int inj_cyc,
                               output logic [31:0] hi, output logic [31:0] lo,
                               output int done_cyc, output int done_cnt,
                               output int wr_cnt, output int busy_cnt);
    hi = '0;
    lo = '0;
    done_cyc = 0;
    done_cnt = 0;
    wr_cnt   = 0;
    busy_cnt = 0;
    for (int c = 1; c <= ncyc; c++) begin
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        done_cnt++;
        if (done_cyc == 0) begin
          done_cyc = c;
          hi = bus.hi_wd;
          lo = bus.lo_wd;
        end
      end
      if (bus.hi_wr) wr_cnt++;
      if (bus.lo_wr) wr_cnt++;
      if (c == inj_cyc) begin
        case (inj_kind)
          INJ_START: begin
            bus.start = 1'b1;
            bus.op    = MDU_MULTU;
            bus.a     = $urandom;
            bus.b     = $urandom;
          end
          INJ_CANCEL: bus.cancel = 1'b1;
          INJ_RESET: begin
            rst_n = 1'b0;
            #1;
            checkOutput("reset_mid_op_outputs",
                        64'({bus.busy, bus.done, bus.hi_wr, bus.lo_wr}), 64'd0);
          end
          default: ;
        endcase
      end
      if (c == inj_cyc + 1) begin
        bus.start  = 1'b0;
        bus.cancel = 1'b0;
      end
      if (inj_kind == INJ_RESET && c == inj_cyc + 2) rst_n = 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic runCase(input string name, input mdu_op_e op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_hi,
                         input logic [31:0] exp_lo, input bit full);
    logic [31:0] hi, lo;
    int done_cyc, done_cnt, wr_cnt, busy_cnt;
    applyStimulus(op, a, b);
    collectResult(LAT + 3, INJ_NONE, 0, hi, lo, done_cyc, done_cnt, wr_cnt, busy_cnt);
    checkOutput({name, "_hi"}, 64'(hi), 64'(exp_hi));
    checkOutput({name, "_lo"}, 64'(lo), 64'(exp_lo));
    checkOutput({name, "_latency"}, 64'(done_cyc), 64'(LAT));
    if (full) begin
      checkOutput({name, "_pulses"}, 64'({16'(done_cnt), 16'(wr_cnt)}), 64'({16'd1, 16'd2}));
      checkOutput({name, "_busy_cycles"}, 64'(busy_cnt), 64'(LAT));
    end
  endtask

  vec_t vecs[10];

  initial begin
    logic [31:0] hi, lo, mhi, mlo, ra, rb;
    int done_cyc, done_cnt, wr_cnt, busy_cnt;
    mdu_op_e rop;

    n_cmp = 0;
    n_err = 0;
    vecs[0] = '{MDU_MULT,  32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA};
    vecs[1] = '{MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[2] = '{MDU_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3] = '{MDU_DIVU,  32'hFFFF_FFF9, 32'h0000_0002, 32'h0000_0001, 32'h7FFF_FFFC};
    vecs[4] = '{MDU_DIVU,  32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 32'hFFFF_FFFF};
    vecs[5] = '{MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[6] = '{MDU_DIV,   32'hFEDC_BA98, 32'h0000_0000, 32'hFEDC_BA98, 32'hFFFF_FFFF};
    vecs[7] = '{MDU_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
    vecs[8] = '{MDU_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vecs[9] = '{MDU_DIV,   32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0003};

    rst_n      = 1'b0;
    bus.start  = 1'b0;
    bus.cancel = 1'b0;
    bus.op     = MDU_MULT;
    bus.a      = '0;
    bus.b      = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_ctrl", 64'({bus.busy, bus.done, bus.hi_wr, bus.lo_wr}), 64'd0);
    checkOutput("reset_data", {bus.hi_wd, bus.lo_wd}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] directed vector table");
    for (int i = 0; i < 10; i++) begin
      runCase($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
              vecs[i].exp_hi, vecs[i].exp_lo, 1'b1);
    end

    $display("[TB] start while busy");
    applyStimulus(MDU_MULT, 32'hFFFF_FFFE, 32'h0000_0003);
    collectResult(LAT + 3, INJ_START, 10, hi, lo, done_cyc, done_cnt, wr_cnt, busy_cnt);
    checkOutput("busy_start_hi", 64'(hi), 64'hFFFF_FFFF);
    checkOutput("busy_start_lo", 64'(lo), 64'hFFFF_FFFA);
    checkOutput("busy_start_latency", 64'(done_cyc), 64'(LAT));
    checkOutput("busy_start_busy_cycles", 64'(busy_cnt), 64'(LAT));

    $display("[TB] cancel during run");
    applyStimulus(MDU_DIVU, 32'h0BAD_F00D, 32'h0000_0013);
    collectResult(LAT + 3, INJ_CANCEL, 20, hi, lo, done_cyc, done_cnt, wr_cnt, busy_cnt);
    checkOutput("cancel_pulses", 64'({16'(done_cnt), 16'(wr_cnt)}), 64'd0);
    checkOutput("cancel_busy_cycles", 64'(busy_cnt), 64'd20);

    $display("[TB] start and cancel together in idle");
    bus.start  = 1'b1;
    bus.cancel = 1'b1;
    bus.op     = MDU_MULTU;
    bus.a      = 32'd5;
    bus.b      = 32'd6;
    @(negedge clk);
    bus.start  = 1'b0;
    bus.cancel = 1'b0;
    collectResult(4, INJ_NONE, 0, hi, lo, done_cyc, done_cnt, wr_cnt, busy_cnt);
    checkOutput("start_cancel_busy_cycles", 64'(busy_cnt), 64'd0);

    $display("[TB] back-to-back after write-back");
    applyStimulus(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    collectResult(LAT, INJ_NONE, 0, hi, lo, done_cyc, done_cnt, wr_cnt, busy_cnt);
    checkOutput("b2b_first_lo", 64'(lo), 64'h0000_0001);
    checkOutput("b2b_first_latency", 64'(done_cyc), 64'(LAT));
    runCase("b2b_second", MDU_DIV, 32'hFFFF_FFF9, 32'h0000_0002,
            32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b1);

    $display("[TB] reset mid-operation");
    applyStimulus(MDU_MULT, 32'h0001_2345, 32'h0000_6789);
    collectResult(LAT + 3, INJ_RESET, 15, hi, lo, done_cyc, done_cnt, wr_cnt, busy_cnt);
    checkOutput("reset_op_pulses", 64'({16'(done_cnt), 16'(wr_cnt)}), 64'd0);
    checkOutput("reset_op_busy_cycles", 64'(busy_cnt), 64'd15);
    refModel(MDU_DIVU, 32'd100, 32'd7, mhi, mlo);
    runCase("after_reset", MDU_DIVU, 32'd100, 32'd7, mhi, mlo, 1'b1);

    $display("[TB] randomized operations");
    for (int i = 0; i < 24; i++) begin
      rop = mdu_op_e'(2'($urandom_range(3, 0)));
      ra  = $urandom;
      if ($urandom_range(3, 0) == 0) ra = 32'($urandom_range(255, 0)) | (ra & 32'h8000_0000);
      rb  = $urandom;
      if ($urandom_range(2, 0) == 0) rb = 32'($urandom_range(15, 0));
      if ($urandom_range(5, 0) == 0) rb = 32'hFFFF_FFFF - 32'($urandom_range(3, 0));
      refModel(rop, ra, rb, mhi, mlo);
      runCase($sformatf("rand%0d_op%0d", i, rop), rop, ra, rb, mhi, mlo, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
